// File: rtl/rle_encoder_p.sv
// Parametrised run-length encoder: reads symbols from port A, packs {symbol,count} records LSB-first, writes words back.
// Optional RLE_ABORT_EN adds an abort input that ends a run early.
module rle_encoder_p #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned SYM_W  = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       message_addr,
    input  logic [31:0]       message_size,
    input  logic [31:0]       rle_addr,
`ifdef RLE_ABORT_EN
    input  logic              abort,
`endif
    output logic [31:0]       rle_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [DATA_W-1:0] port_A_data_in,
    input  logic [DATA_W-1:0] port_A_data_out
);

    localparam int unsigned REC_W      = SYM_W + CNT_W;
    localparam int unsigned SPW        = DATA_W / SYM_W;
    localparam int unsigned RPW        = DATA_W / REC_W;
    localparam int unsigned WORD_BYTES = DATA_W / 8;
    localparam int unsigned IDX_W      = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int unsigned SLOT_W     = (RPW > 1) ? $clog2(RPW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SCAN, EMIT, FLUSH, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   word;
    logic [IDX_W-1:0]    sym_idx;
    logic [SYM_W-1:0]    run_sym;
    logic [CNT_W-1:0]    run_cnt;
    logic                run_valid;
    logic [31:0]         remaining;
    logic [DATA_W-1:0]   out_word;
    logic [SLOT_W-1:0]   slot;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         rec_cnt;
    logic [31:0]         wr_words;

    logic [SYM_W-1:0]    cur_sym;
    logic [REC_W-1:0]    rec;
    logic [DATA_W-1:0]   merged;
    logic                slot_full;
    logic                last_sym;
    logic                scan_emit;
    logic                abort_hit;

    assign port_A_clk = clk;

`ifdef RLE_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Current symbol, pending record and the output word with that record inserted
    always_comb begin
        cur_sym   = SYM_W'(word >> (32'(sym_idx) * SYM_W));
        rec       = {run_sym, run_cnt};
        merged    = out_word | (DATA_W'(rec) << (32'(slot) * REC_W));
        slot_full = (32'(slot) == RPW - 1);
        last_sym  = (32'(sym_idx) == SPW - 1);
        scan_emit = (state == SCAN) && run_valid &&
                    ((remaining == 32'd0) || (cur_sym != run_sym) || (run_cnt == CNT_MAX));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            word           <= '0;
            sym_idx        <= '0;
            run_sym        <= '0;
            run_cnt        <= '0;
            run_valid      <= 1'b0;
            remaining      <= '0;
            out_word       <= '0;
            slot           <= '0;
            rd_addr        <= '0;
            wr_addr        <= '0;
            rec_cnt        <= '0;
            wr_words       <= '0;
            rle_size       <= '0;
            done           <= 1'b0;
            port_A_addr    <= '0;
            port_A_we      <= 1'b0;
            port_A_data_in <= '0;
        end else if (abort_hit && (state != IDLE)) begin
            // Only words already on the bus count toward the reported size
            state     <= IDLE;
            port_A_we <= 1'b0;
            done      <= 1'b1;
            rle_size  <= 32'(64'(wr_words) * 64'(WORD_BYTES));
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        rle_size  <= '0;
                        rec_cnt   <= '0;
                        wr_words  <= '0;
                        remaining <= message_size;
                        rd_addr   <= ADDR_W'(message_addr);
                        wr_addr   <= ADDR_W'(rle_addr);
                        sym_idx   <= '0;
                        slot      <= '0;
                        out_word  <= '0;
                        run_valid <= 1'b0;
                        if (message_size == 32'd0) begin
                            state <= DONE;
                        end else begin
                            port_A_addr <= ADDR_W'(message_addr);
                            state       <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    rd_addr <= ADDR_W'(rd_addr + ADDR_W'(WORD_BYTES));
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    word  <= port_A_data_out;
                    state <= SCAN;
                end
                SCAN: begin
                    if (remaining == 32'd0) begin
                        run_valid <= 1'b0;
                        state     <= run_valid ? EMIT : FLUSH;
                    end else begin
                        run_sym   <= cur_sym;
                        run_cnt   <= (scan_emit || !run_valid) ? CNT_W'(1) : CNT_W'(run_cnt + CNT_W'(1));
                        run_valid <= 1'b1;
                        remaining <= remaining - 32'd1;
                        sym_idx   <= last_sym ? '0 : IDX_W'(sym_idx + IDX_W'(1));
                        if (scan_emit) begin
                            state <= EMIT;
                        end else if (last_sym && (remaining != 32'd1)) begin
                            port_A_addr <= rd_addr;
                            state       <= RD_REQ;
                        end
                    end
                    // The write, when the word fills, is on the bus during EMIT
                    if (scan_emit) begin
                        rec_cnt  <= rec_cnt + 32'd1;
                        rle_size <= 32'(((64'(rec_cnt) + 64'd1) * 64'(REC_W)) >> 3);
                        if (slot_full) begin
                            port_A_we      <= 1'b1;
                            port_A_addr    <= wr_addr;
                            port_A_data_in <= merged;
                            wr_addr        <= ADDR_W'(wr_addr + ADDR_W'(WORD_BYTES));
                            wr_words       <= wr_words + 32'd1;
                            out_word       <= '0;
                            slot           <= '0;
                        end else begin
                            out_word <= merged;
                            slot     <= SLOT_W'(slot + SLOT_W'(1));
                        end
                    end
                end
                EMIT: begin
                    port_A_we <= 1'b0;
                    if (remaining == 32'd0) begin
                        state <= run_valid ? SCAN : FLUSH;
                    end else if (sym_idx == '0) begin
                        port_A_addr <= rd_addr;
                        state       <= RD_REQ;
                    end else begin
                        state <= SCAN;
                    end
                end
                FLUSH: begin
                    if (slot != '0) begin
                        port_A_we      <= 1'b1;
                        port_A_addr    <= wr_addr;
                        port_A_data_in <= out_word;
                        wr_addr        <= ADDR_W'(wr_addr + ADDR_W'(WORD_BYTES));
                        wr_words       <= wr_words + 32'd1;
                        out_word       <= '0;
                        slot           <= '0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    port_A_we <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_encoder_p.sv
// Bench for rle_encoder_p: SRAM model with write log, queue-based RLE reference model, random and directed runs.
module tb_rle_encoder_p;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic        port_A_we;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;
`ifdef RLE_ABORT_EN
    logic        abort;
`endif

    rle_encoder_p dut (
        .clk(clk), .nreset(nreset), .start(start),
        .message_addr(message_addr), .message_size(message_size), .rle_addr(rle_addr),
`ifdef RLE_ABORT_EN
        .abort(abort),
`endif
        .rle_size(rle_size), .done(done), .port_A_clk(port_A_clk),
        .port_A_addr(port_A_addr), .port_A_we(port_A_we),
        .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Input image is bench-owned; every DUT write goes to the log instead
    logic [31:0] in_mem [0:16383];
    logic [15:0] log_addr [0:8191];
    logic [31:0] log_data [0:8191];
    int          wr_count = 0;

    always @(posedge clk) begin
        port_A_data_out <= in_mem[port_A_addr[15:2]];
        if (port_A_we) begin
            if (wr_count < 8192) begin
                log_addr[wr_count] <= port_A_addr;
                log_data[wr_count] <= port_A_data_in;
            end
            wr_count <= wr_count + 1;
        end
    end

    logic [7:0]  msg[$];
    logic [31:0] exp_words[$];
    int          exp_size;

    task automatic make_random_msg(input int n);
        msg.delete();
        while (msg.size() < n) begin
            logic [7:0] s;
            int len;
            s   = 8'(8'h30 + 8'($urandom_range(0, 2)));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 400) : $urandom_range(1, 4);
            for (int j = 0; j < len && msg.size() < n; j++) msg.push_back(s);
        end
    endtask

    // Runs capped at 255, two 16-bit records per word, low record first
    task automatic build_model();
        logic [15:0] recs[$];
        logic [7:0]  cur;
        int          cnt;
        recs.delete();
        exp_words.delete();
        exp_size = 0;
        if (msg.size() == 0) return;
        cur = msg[0];
        cnt = 1;
        for (int i = 1; i < msg.size(); i++) begin
            if (msg[i] == cur && cnt < 255) cnt++;
            else begin
                recs.push_back({cur, 8'(cnt)});
                cur = msg[i];
                cnt = 1;
            end
        end
        recs.push_back({cur, 8'(cnt)});
        for (int k = 0; k < recs.size(); k += 2)
            exp_words.push_back((k + 1 < recs.size()) ? {recs[k+1], recs[k]} : {16'h0000, recs[k]});
        exp_size = recs.size() * 2;
    endtask

    // Unused bytes of the last word are random so stray symbols would show up
    task automatic load_msg(input logic [31:0] base);
        for (int i = 0; i < (msg.size() + 3) / 4; i++) begin
            logic [31:0] w;
            w = $urandom();
            for (int j = 0; j < 4; j++)
                if (4 * i + j < msg.size()) w[j*8 +: 8] = msg[4*i+j];
            in_mem[32'(base[15:2]) + i] = w;
        end
    endtask

    task automatic run(input logic [31:0] maddr, input logic [31:0] raddr, output bit ok, output int cyc);
        @(negedge clk);
        message_addr = maddr;
        message_size = msg.size();
        rle_addr     = raddr;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        ok    = 1'b0;
        while (cyc < 4 * msg.size() + 100) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        total++; if (rle_size !== 32'd0) begin bad++; $display("FAIL reset rle_size: got %h want 0", rle_size); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        total++; if (port_A_we !== 1'b0) begin bad++; $display("FAIL reset we: got %b want 0", port_A_we); end
        total++; if (port_A_addr !== 16'h0) begin bad++; $display("FAIL reset addr: got %h want 0", port_A_addr); end
        total++; if (port_A_data_in !== 32'h0) begin bad++; $display("FAIL reset data_in: got %h want 0", port_A_data_in); end
    endtask

    task automatic test_directed();
        logic [31:0] spec_w0 [3] = '{32'h42014107, 32'hAA2DAAFF, 32'h03010401};
        int          spec_sz [3] = '{4, 4, 6};
        logic [31:0] raddr = 32'h0000_0100;
        for (int c = 0; c < 3; c++) begin
            bit ok;
            int cyc, pos;
            msg.delete();
            if (c == 0) begin
                repeat (7) msg.push_back(8'h41);
                msg.push_back(8'h42);
            end else if (c == 1) begin
                repeat (300) msg.push_back(8'hAA);
            end else begin
                msg.push_back(8'h04); msg.push_back(8'h03); msg.push_back(8'h02);
            end
            build_model();
            load_msg(32'h0);
            pos = wr_count;
            run(32'h0, raddr, ok, cyc);
            total++; if (!ok) begin bad++; $display("FAIL dir%0d timeout: cycles %0d", c, cyc); end
            total++; if (rle_size !== 32'(spec_sz[c])) begin bad++; $display("FAIL dir%0d rle_size: got %0d want %0d", c, rle_size, spec_sz[c]); end
            total++; if (wr_count - pos !== exp_words.size()) begin bad++; $display("FAIL dir%0d writes: got %0d want %0d", c, wr_count - pos, exp_words.size()); end
            total++; if (log_data[pos] !== spec_w0[c] || log_addr[pos] !== 16'h0100) begin bad++; $display("FAIL dir%0d word0: got %h@%h want %h@0100", c, log_data[pos], log_addr[pos], spec_w0[c]); end
            if (c == 2) begin
                total++; if (log_data[pos+1] !== 32'h00000201 || log_addr[pos+1] !== 16'h0104) begin bad++; $display("FAIL dir2 word1: got %h@%h want 00000201@0104", log_data[pos+1], log_addr[pos+1]); end
            end
        end
    endtask

    task automatic test_empty();
        bit ok;
        int cyc, pos;
        msg.delete();
        pos = wr_count;
        run(32'h0, 32'h200, ok, cyc);
        total++; if (!ok || cyc > 2) begin bad++; $display("FAIL empty latency: done=%b after %0d cycles want <=2", done, cyc); end
        total++; if (wr_count != pos) begin bad++; $display("FAIL empty writes: got %0d want 0", wr_count - pos); end
        total++; if (rle_size !== 32'd0) begin bad++; $display("FAIL empty rle_size: got %0d want 0", rle_size); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            bit ok;
            int cyc, pos, n;
            logic [31:0] base, maddr, raddr;
            n = (it == 0) ? 1 : (it == 1) ? 4 : (it == 2) ? 5 : $urandom_range(1, 600);
            make_random_msg(n);
            build_model();
            base  = 32'($urandom_range(0, 2047)) << 2;
            maddr = {16'($urandom()), base[15:0]};
            // Some outputs start near the top of the address space to exercise wrap
            raddr = (it % 3 == 0) ? {16'($urandom()), 16'hFFF0} : 32'h8000 + (32'($urandom_range(0, 1023)) << 2);
            load_msg(base);
            pos = wr_count;
            run(maddr, raddr, ok, cyc);
            total++; if (!ok) begin bad++; $display("FAIL rand%0d timeout: cycles %0d n=%0d", it, cyc, n); end
            total++; if (rle_size !== 32'(exp_size)) begin bad++; $display("FAIL rand%0d rle_size: got %0d want %0d", it, rle_size, exp_size); end
            total++; if (wr_count - pos !== exp_words.size()) begin bad++; $display("FAIL rand%0d writes: got %0d want %0d", it, wr_count - pos, exp_words.size()); end
            for (int k = 0; k < exp_words.size(); k++) begin
                total++;
                if (log_data[pos+k] !== exp_words[k] || log_addr[pos+k] !== 16'(raddr + 32'(4 * k))) begin
                    bad++;
                    $display("FAIL rand%0d word%0d: got %h@%h want %h@%h", it, k, log_data[pos+k], log_addr[pos+k], exp_words[k], 16'(raddr + 32'(4 * k)));
                end
            end
        end
    endtask

    // A second start while busy must not disturb the run; the next run follows immediately
    task automatic test_back_to_back();
        bit ok;
        int cyc, pos;
        make_random_msg(40);
        build_model();
        load_msg(32'h400);
        pos = wr_count;
        @(negedge clk);
        message_addr = 32'h400; message_size = 40; rle_addr = 32'h9000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        message_addr = 32'h0; message_size = 3; rle_addr = 32'hA000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; ok = 1'b0;
        while (cyc < 300) begin
            if (done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk); cyc++;
        end
        total++; if (!ok) begin bad++; $display("FAIL busy timeout: cycles %0d", cyc); end
        total++; if (rle_size !== 32'(exp_size)) begin bad++; $display("FAIL busy rle_size: got %0d want %0d", rle_size, exp_size); end
        total++; if (wr_count - pos !== exp_words.size()) begin bad++; $display("FAIL busy writes: got %0d want %0d", wr_count - pos, exp_words.size()); end
        for (int k = 0; k < exp_words.size(); k++) begin
            total++;
            if (log_data[pos+k] !== exp_words[k] || log_addr[pos+k] !== 16'(32'h9000 + 32'(4 * k))) begin
                bad++; $display("FAIL busy word%0d: got %h@%h want %h", k, log_data[pos+k], log_addr[pos+k], exp_words[k]);
            end
        end
        make_random_msg(17);
        build_model();
        load_msg(32'h800);
        pos = wr_count;
        run(32'h800, 32'hB000, ok, cyc);
        total++; if (!ok || rle_size !== 32'(exp_size)) begin bad++; $display("FAIL b2b rle_size: got %0d want %0d ok=%b", rle_size, exp_size, ok); end
        total++; if (wr_count - pos !== exp_words.size() || log_data[pos] !== exp_words[0]) begin
            bad++; $display("FAIL b2b word0: got %h writes %0d want %h writes %0d", log_data[pos], wr_count - pos, exp_words[0], exp_words.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int cyc, pos;
        msg.delete();
        repeat (7) msg.push_back(8'h41);
        msg.push_back(8'h42);
        build_model();
        load_msg(32'h0);
        pos = wr_count;
        @(negedge clk);
        message_addr = 32'h0; message_size = 8; rle_addr = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        nreset = 1'b0;
        #1;
        test_reset();
        repeat (3) @(negedge clk);
        total++; if (wr_count != pos) begin bad++; $display("FAIL rstmid writes: got %0d want 0", wr_count - pos); end
        nreset = 1'b1;
        pos = wr_count;
        run(32'h0, 32'h100, ok, cyc);
        total++; if (!ok || rle_size !== 32'd4) begin bad++; $display("FAIL rstmid rle_size: got %0d want 4 ok=%b", rle_size, ok); end
        total++; if (wr_count - pos !== 1 || log_data[pos] !== 32'h42014107) begin
            bad++; $display("FAIL rstmid word: got %h writes %0d want 42014107 writes 1", log_data[pos], wr_count - pos);
        end
    endtask

`ifdef RLE_ABORT_EN
    task automatic test_abort();
        int cyc, pos;
        bit seen;
        msg.delete();
        msg.push_back(8'h04); msg.push_back(8'h03); msg.push_back(8'h02);
        load_msg(32'h0);
        pos = wr_count;
        @(negedge clk);
        message_addr = 32'h0; message_size = 3; rle_addr = 32'h100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (cyc < 50) begin
            if (port_A_we === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk); cyc++;
        end
        total++; if (!seen) begin bad++; $display("FAIL abort first write: none within %0d cycles", cyc); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (wr_count - pos !== 1) begin bad++; $display("FAIL abort writes: got %0d want 1", wr_count - pos); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort done: got %b want 1", done); end
        total++; if (rle_size !== 32'd4) begin bad++; $display("FAIL abort rle_size: got %0d want 4", rle_size); end
    endtask
`endif

    initial begin
        nreset = 1'b0;
        start = 1'b0;
        message_addr = '0;
        message_size = '0;
        rle_addr = '0;
`ifdef RLE_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        nreset = 1'b1;
        test_directed();
        test_empty();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
`ifdef RLE_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
